// File: rtl/instr_seq_ctrl.sv
// ---------------------------------------------------------------------------
// instr_seq_ctrl
//
// Purpose
//   Multi-cycle sequencer for a tiny 8-bit, 8-register instruction set.
//   Each accepted instruction reads its operands from an external register
//   file, computes the result and writes it back. Only one instruction is in
//   flight at a time.
//
//   Instruction word: [7:6] opcode, [5:3] rd, [2:0] rs / imm3
//     00 MOV  rd <= rs
//     01 ADD  rd <= rd + rs   (carry <= bit 8 of the 9-bit sum)
//     10 AND  rd <= rd & rs
//     11 LDI  rd <= {5'b0, imm3}
//
//   State flow:
//     IDLE -> RD_S -> EXEC -> WB -> IDLE            (MOV)
//     IDLE -> RD_S -> RD_D -> EXEC -> WB -> IDLE    (ADD, AND)
//     IDLE -> EXEC -> WB -> IDLE                    (LDI)
//
// Handshake
//   instr_valid/instr_ready follow strict valid/ready rules: an instruction
//   is transferred on a rising edge where both are 1. instr_ready is a
//   registered output that is 1 only in IDLE (and only after the first edge
//   out of reset); instr_valid is ignored whenever instr_ready is 0, and the
//   upstream block holds instr_data stable until the transfer happens.
//
// Ports
//   clk           rising-edge clock
//   reset         synchronous, active-low reset
//   instr_valid   upstream instruction word valid
//   instr_data    instruction word (see above)
//   instr_ready   block can accept an instruction this cycle
//   read_reg_no   register-file read index (rs in RD_S, rd in RD_D, else 0)
//   read_data     register-file read data, combinational from read_reg_no
//   write_reg_no  register-file write index (held after WB)
//   write_data    register-file write data (held after WB)
//   reg_write     register-file write enable, high for the single WB cycle
//   busy          instruction in flight (every state except IDLE)
//   carry         carry out of the last ADD
//   zero          last written result was zero
//   retired_cnt   count of completed instructions, wraps 255 -> 0
//
// Every output is a flop; no input reaches an output combinationally.
// ---------------------------------------------------------------------------
module instr_seq_ctrl (
  input  logic       clk,
  input  logic       reset,
  input  logic       instr_valid,
  input  logic [7:0] instr_data,
  output logic       instr_ready,
  output logic [2:0] read_reg_no,
  input  logic [7:0] read_data,
  output logic [2:0] write_reg_no,
  output logic [7:0] write_data,
  output logic       reg_write,
  output logic       busy,
  output logic       carry,
  output logic       zero,
  output logic [7:0] retired_cnt
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_RD_S = 3'd1,
    S_RD_D = 3'd2,
    S_EXEC = 3'd3,
    S_WB   = 3'd4
  } state_t;

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_LDI = 2'b11;

  // State and datapath registers
  state_t     r_state;
  logic [7:0] r_instr;
  logic [7:0] r_op_a;
  logic [7:0] r_op_b;

  // Registered outputs
  logic       r_instr_ready;
  logic [2:0] r_read_reg_no;
  logic [2:0] r_write_reg_no;
  logic [7:0] r_write_data;
  logic       r_reg_write;
  logic       r_busy;
  logic       r_carry;
  logic       r_zero;
  logic [7:0] r_retired_cnt;

  // Decode of the latched instruction
  logic [1:0] w_opcode;
  logic [2:0] w_rd;
  logic [2:0] w_rs;
  logic [1:0] w_new_opcode;
  logic [8:0] w_sum;
  logic [7:0] w_result;

  assign w_opcode     = r_instr[7:6];
  assign w_rd         = r_instr[5:3];
  assign w_rs         = r_instr[2:0];
  assign w_new_opcode = instr_data[7:6];

  // 9-bit sum so the carry out of bit 7 is available for ADD.
  assign w_sum = {1'b0, r_op_a} + {1'b0, r_op_b};

  always_comb begin
    w_result = 8'h00;
    case (w_opcode)
      OP_MOV:  w_result = r_op_b;
      OP_ADD:  w_result = w_sum[7:0];
      OP_AND:  w_result = r_op_a & r_op_b;
      OP_LDI:  w_result = {5'b00000, w_rs};
      default: w_result = 8'h00;
    endcase
  end

  // -------------------------------------------------------------------------
  // Sequencer. read_reg_no is loaded on the edge that enters RD_S / RD_D so
  // the register file has the whole cycle to answer, and is cleared on the
  // edge that leaves them.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state        <= S_IDLE;
      r_instr        <= 8'h00;
      r_op_a         <= 8'h00;
      r_op_b         <= 8'h00;
      r_instr_ready  <= 1'b0;
      r_read_reg_no  <= 3'd0;
      r_write_reg_no <= 3'd0;
      r_write_data   <= 8'h00;
      r_reg_write    <= 1'b0;
      r_busy         <= 1'b0;
      r_carry        <= 1'b0;
      r_zero         <= 1'b0;
      r_retired_cnt  <= 8'h00;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_reg_write   <= 1'b0;
          r_read_reg_no <= 3'd0;
          // instr_ready is 0 for the first IDLE cycle after reset, so the
          // transfer qualifier uses the registered ready, not a constant.
          if (r_instr_ready && instr_valid) begin
            r_instr       <= instr_data;
            r_instr_ready <= 1'b0;
            r_busy        <= 1'b1;
            if (w_new_opcode == OP_LDI) begin
              r_state <= S_EXEC;
            end else begin
              r_state       <= S_RD_S;
              r_read_reg_no <= instr_data[2:0];
            end
          end else begin
            r_instr_ready <= 1'b1;
            r_busy        <= 1'b0;
          end
        end

        S_RD_S: begin
          r_op_b <= read_data;
          if (w_opcode == OP_MOV) begin
            r_state       <= S_EXEC;
            r_read_reg_no <= 3'd0;
          end else begin
            r_state       <= S_RD_D;
            r_read_reg_no <= w_rd;
          end
        end

        S_RD_D: begin
          r_op_a        <= read_data;
          r_state       <= S_EXEC;
          r_read_reg_no <= 3'd0;
        end

        S_EXEC: begin
          r_write_data   <= w_result;
          r_write_reg_no <= w_rd;
          if (w_opcode == OP_ADD) begin
            r_carry <= w_sum[8];
          end
          r_reg_write <= 1'b1;
          r_state     <= S_WB;
        end

        S_WB: begin
          // write_reg_no / write_data are deliberately left untouched here:
          // the register-file write is level-sensitive and they must stay
          // stable until the next EXEC.
          r_reg_write   <= 1'b0;
          r_zero        <= (r_write_data == 8'h00);
          r_retired_cnt <= r_retired_cnt + 8'd1;
          r_instr_ready <= 1'b1;
          r_busy        <= 1'b0;
          r_state       <= S_IDLE;
        end

        default: begin
          r_state       <= S_IDLE;
          r_reg_write   <= 1'b0;
          r_read_reg_no <= 3'd0;
          r_instr_ready <= 1'b0;
          r_busy        <= 1'b0;
        end
      endcase
    end
  end

  assign instr_ready  = r_instr_ready;
  assign read_reg_no  = r_read_reg_no;
  assign write_reg_no = r_write_reg_no;
  assign write_data   = r_write_data;
  assign reg_write    = r_reg_write;
  assign busy         = r_busy;
  assign carry        = r_carry;
  assign zero         = r_zero;
  assign retired_cnt  = r_retired_cnt;

endmodule
